// File: rtl/reg_window_engine_if.sv
// Memory-bus link between the register-window engine (master) and memory (slave).
// The request side is registered in the master; bus_rdata is qualified by bus_ack.
interface reg_window_engine_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/reg_window_engine.sv
// Multi-channel register-window engine: N_CH operand channels share one bus master (round-robin).
// Define REGWIN_FWD_EN to forward pending write data into hazarding reads instead of stalling them.
module reg_window_engine #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int RW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      base_addr,
  input  logic [N_CH-1:0]    ch_go,
  input  logic [N_CH*3-1:0]  ch_op,
  input  logic [N_CH*RW-1:0] ch_reg,
  input  logic [N_CH*2-1:0]  ch_flags,
  input  logic [N_CH*DW-1:0] ch_wdata,
  output logic [N_CH*DW-1:0] ch_value,
  output logic [N_CH*DW-1:0] ch_ptr,
  output logic [N_CH-1:0]    ch_busy,
  output logic [N_CH-1:0]    ch_done,
  reg_window_engine_if.master bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_READ_P = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_WRITE_P= 3'd4;
  localparam logic [2:0] OP_LOAD   = 3'd5;

  typedef enum logic [1:0] {IDLE, PEND, BUS, DONE} st_e;

  st_e           st_q    [N_CH];
  st_e           st_d    [N_CH];
  logic [2:0]    op_q    [N_CH];
  logic [2:0]    op_d    [N_CH];
  logic [RW-1:0] reg_q   [N_CH];
  logic [RW-1:0] reg_d   [N_CH];
  logic [1:0]    flags_q [N_CH];
  logic [1:0]    flags_d [N_CH];
  logic [DW-1:0] wdata_q [N_CH];
  logic [DW-1:0] wdata_d [N_CH];
  logic [DW-1:0] value_q [N_CH];
  logic [DW-1:0] value_d [N_CH];
  logic [DW-1:0] ptr_q   [N_CH];
  logic [DW-1:0] ptr_d   [N_CH];

  logic [CW-1:0] rr_q, rr_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          is_rd   [N_CH];
  logic          is_wr   [N_CH];
  logic [AW-1:0] addr    [N_CH];
  logic [DW-1:0] wr_data [N_CH];
  logic [N_CH-1:0] hazard;
  logic [N_CH-1:0] elig;
  logic          gnt_vld;
  logic [CW-1:0] gnt_idx;
  logic          ack_ok;
`ifdef REGWIN_FWD_EN
  logic [DW-1:0] fwd_data [N_CH];
`endif

  // Per-channel address/data as seen now; ptr only changes when its own channel completes.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      is_rd[i] = (op_q[i] == OP_READ)  || (op_q[i] == OP_READ_P);
      is_wr[i] = (op_q[i] == OP_WRITE) || (op_q[i] == OP_WRITE_P);
      if ((op_q[i] == OP_READ_P) || (op_q[i] == OP_WRITE_P))
        addr[i] = base_addr + AW'(ptr_q[i]);
      else
        addr[i] = base_addr + AW'(reg_q[i]);
      if (op_q[i] == OP_WRITE_P)
        wr_data[i] = value_q[i];
      else if (flags_q[i] == 2'b01)
        wr_data[i] = wdata_q[i] + 1'b1;
      else if (flags_q[i] == 2'b10)
        wr_data[i] = wdata_q[i] - 1'b1;
      else
        wr_data[i] = wdata_q[i];
    end
  end

  always_comb begin
    hazard = '0;
    elig   = '0;
    for (int i = 0; i < N_CH; i++) begin
`ifdef REGWIN_FWD_EN
      fwd_data[i] = '0;
`endif
      for (int j = N_CH - 1; j >= 0; j--) begin
        if ((j != i) && is_rd[i] && is_wr[j] &&
            ((st_q[j] == PEND) || (st_q[j] == BUS)) && (addr[i] == addr[j])) begin
          hazard[i] = 1'b1;
`ifdef REGWIN_FWD_EN
          fwd_data[i] = wr_data[j];
`endif
        end
      end
      elig[i] = (st_q[i] == PEND) && (is_rd[i] || is_wr[i]) && !hazard[i];
    end
  end

  // Descending scan so the last hit is the nearest channel at/after the pointer.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  assign ack_ok = bus_req_q && bus.bus_ack;

  always_comb begin
    rr_d        = rr_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (gnt_vld && !bus_req_q) begin
      rr_d        = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      bus_req_d   = 1'b1;
      bus_we_d    = is_wr[gnt_idx];
      bus_addr_d  = addr[gnt_idx];
      bus_wdata_d = is_wr[gnt_idx] ? wr_data[gnt_idx] : '0;
    end else if (ack_ok) begin
      bus_req_d = 1'b0;
    end

    for (int i = 0; i < N_CH; i++) begin
      st_d[i]    = st_q[i];
      op_d[i]    = op_q[i];
      reg_d[i]   = reg_q[i];
      flags_d[i] = flags_q[i];
      wdata_d[i] = wdata_q[i];
      value_d[i] = value_q[i];
      ptr_d[i]   = ptr_q[i];
      case (st_q[i])
        IDLE: if (ch_go[i]) begin
          st_d[i]    = PEND;
          op_d[i]    = ch_op[i*3 +: 3];
          reg_d[i]   = ch_reg[i*RW +: RW];
          flags_d[i] = ch_flags[i*2 +: 2];
          wdata_d[i] = ch_wdata[i*DW +: DW];
        end
        PEND: begin
          if (!(is_rd[i] || is_wr[i])) begin
            st_d[i] = DONE;
            if (op_q[i] == OP_LOAD) begin
              value_d[i] = wdata_q[i];
              ptr_d[i]   = wdata_q[i];
            end
`ifdef REGWIN_FWD_EN
          end else if (hazard[i]) begin
            st_d[i]    = DONE;
            value_d[i] = fwd_data[i];
            if (op_q[i] == OP_READ) ptr_d[i] = fwd_data[i];
`endif
          end else if (gnt_vld && !bus_req_q && (gnt_idx == CW'(i))) begin
            st_d[i] = BUS;
          end
        end
        BUS: if (ack_ok) begin
          st_d[i] = DONE;
          case (op_q[i])
            OP_READ: begin
              value_d[i] = bus.bus_rdata;
              ptr_d[i]   = bus.bus_rdata;
            end
            OP_READ_P: value_d[i] = bus.bus_rdata;
            OP_WRITE:  ptr_d[i]   = wr_data[i];
            default: ;
          endcase
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q        <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]    <= IDLE;
        op_q[i]    <= '0;
        reg_q[i]   <= '0;
        flags_q[i] <= '0;
        wdata_q[i] <= '0;
        value_q[i] <= '0;
        ptr_q[i]   <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]    <= st_d[i];
        op_q[i]    <= op_d[i];
        reg_q[i]   <= reg_d[i];
        flags_q[i] <= flags_d[i];
        wdata_q[i] <= wdata_d[i];
        value_q[i] <= value_d[i];
        ptr_q[i]   <= ptr_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_value[i*DW +: DW] = value_q[i];
      ch_ptr[i*DW +: DW]   = ptr_q[i];
      ch_busy[i]           = (st_q[i] != IDLE);
      ch_done[i]           = (st_q[i] == DONE);
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_reg_window_engine.sv
// Directed bench for reg_window_engine with a delayed-ack memory responder and a bus log.
// Hazard expectations follow REGWIN_FWD_EN when the bench is built with it.
module tb_reg_window_engine;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int RW   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [AW-1:0]      base_addr = '0;
  logic [N_CH-1:0]    ch_go = '0;
  logic [N_CH*3-1:0]  ch_op = '0;
  logic [N_CH*RW-1:0] ch_reg = '0;
  logic [N_CH*2-1:0]  ch_flags = '0;
  logic [N_CH*DW-1:0] ch_wdata = '0;
  logic [N_CH*DW-1:0] ch_value, ch_ptr;
  logic [N_CH-1:0]    ch_busy, ch_done;

  reg_window_engine_if #(.AW(AW), .DW(DW)) bif ();

  reg_window_engine #(.N_CH(N_CH), .DW(DW), .AW(AW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr),
    .ch_go(ch_go), .ch_op(ch_op), .ch_reg(ch_reg), .ch_flags(ch_flags), .ch_wdata(ch_wdata),
    .ch_value(ch_value), .ch_ptr(ch_ptr), .ch_busy(ch_busy), .ch_done(ch_done),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ack_dly = 0;
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] log_addr[$];
  logic          log_we[$];
  logic [DW-1:0] log_wdata[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks after ack_dly waiting cycles, logs each accepted transfer.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bif.bus_ack = 1'b0;
      if (bif.bus_req && rst) begin
        if (wait_cnt >= ack_dly) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rd_val;
          log_addr.push_back(bif.bus_addr);
          log_we.push_back(bif.bus_we);
          log_wdata.push_back(bif.bus_wdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic set_ch(input int ch, input logic [2:0] op, input logic [RW-1:0] r,
                        input logic [1:0] fl, input logic [DW-1:0] wd);
    ch_op[ch*3 +: 3]     = op;
    ch_reg[ch*RW +: RW]  = r;
    ch_flags[ch*2 +: 2]  = fl;
    ch_wdata[ch*DW +: DW] = wd;
    ch_go[ch]            = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    ch_go = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (ch_busy != '0 && n < budget) begin
      step();
      n++;
    end
    if (ch_busy != '0) check({tag, "_timeout"}, ch_busy, '0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_busy", ch_busy, 0);
    check("rst_value", ch_value, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    base_addr = 32'h100;

    // All four channels together, ack delay 2: grants 0,1,2,3
    ack_dly = 2;
    clear_log();
    for (int c = 0; c < N_CH; c++) set_ch(c, 3'd1, RW'(c), 2'b00, '0);
    step();
    wait_idle("rr4", 80);
    check("rr4_count", log_addr.size(), 4);
    for (int c = 0; c < N_CH && c < log_addr.size(); c++)
      check($sformatf("rr4_addr%0d", c), log_addr[c], 32'h100 + c);

    // Pointer wrapped to 0: ch0 beats ch3
    clear_log();
    set_ch(3, 3'd1, 4'd7, 2'b00, '0);
    set_ch(0, 3'd1, 4'd8, 2'b00, '0);
    step();
    wait_idle("rr2", 40);
    check("rr2_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("rr2_first", log_addr[0], 32'h108);
      check("rr2_second", log_addr[1], 32'h107);
    end

    // ch0 READ reg 3, zero-wait ack
    ack_dly = 0;
    rd_val  = 32'h55;
    set_ch(0, 3'd1, 4'd3, 2'b00, '0);
    step();
    check("rd_done_T0", ch_done[0], 0);
    step();
    check("rd_req_T1", bif.bus_req, 1);
    check("rd_addr", bif.bus_addr, 32'h103);
    check("rd_we", bif.bus_we, 0);
    check("rd_done_T1", ch_done[0], 0);
    step();
    check("rd_done_T2", ch_done[0], 1);
    check("rd_req_T2", bif.bus_req, 0);
    check("rd_value", ch_value[0*DW +: DW], 32'h55);
    check("rd_ptr", ch_ptr[0*DW +: DW], 32'h55);
    step();
    check("rd_idle", ch_busy[0], 0);

    // ch1 WRITE with post-inc wrapping to 0
    set_ch(1, 3'd3, 4'd2, 2'b01, 32'hFFFF_FFFF);
    step();
    step();
    check("wr_we", bif.bus_we, 1);
    check("wr_addr", bif.bus_addr, 32'h102);
    check("wr_wdata", bif.bus_wdata, 32'h0);
    wait_idle("wr", 10);
    check("wr_ptr", ch_ptr[1*DW +: DW], 32'h0);

    // ch3 WRITE with post-dec
    set_ch(3, 3'd3, 4'd1, 2'b10, 32'h0);
    step();
    step();
    check("wrdec_wdata", bif.bus_wdata, 32'hFFFF_FFFF);
    wait_idle("wrdec", 10);

    // NOP: done 1 cycle after go, no bus traffic
    clear_log();
    set_ch(3, 3'd0, 4'd0, 2'b00, '0);
    step();
    step();
    check("nop_done", ch_done[3], 1);
    check("nop_req", bif.bus_req, 0);
    step();
    check("nop_nobus", log_addr.size(), 0);

    // Hazard: ch0 WRITE reg5 and ch1 READ reg5 in the same cycle
    clear_log();
    rd_val = 32'h77;
    set_ch(0, 3'd3, 4'd5, 2'b00, 32'hAA);
    set_ch(1, 3'd1, 4'd5, 2'b00, '0);
    step();
    wait_idle("haz", 40);
`ifdef REGWIN_FWD_EN
    check("haz_count", log_addr.size(), 1);
    if (log_addr.size() >= 1) check("haz_we0", log_we[0], 1);
    check("haz_value", ch_value[1*DW +: DW], 32'hAA);
`else
    check("haz_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("haz_we0", log_we[0], 1);
      check("haz_wdata0", log_wdata[0], 32'hAA);
      check("haz_we1", log_we[1], 0);
      check("haz_addr1", log_addr[1], 32'h105);
    end
    check("haz_value", ch_value[1*DW +: DW], 32'h77);
`endif

    // LOAD ptr = all-ones, then READ_P wraps the address
    set_ch(2, 3'd5, 4'd0, 2'b00, 32'hFFFF_FFFF);
    step();
    step();
    check("load_done", ch_done[2], 1);
    check("load_ptr", ch_ptr[2*DW +: DW], 32'hFFFF_FFFF);
    step();
    base_addr = 32'h2;
    rd_val = 32'h33;
    set_ch(2, 3'd2, 4'd0, 2'b00, '0);
    step();
    step();
    check("rdp_addr", bif.bus_addr, 32'h1);
    step();
    check("rdp_value", ch_value[2*DW +: DW], 32'h33);
    check("rdp_ptr", ch_ptr[2*DW +: DW], 32'hFFFF_FFFF);
    step();

    // Reset while a transfer is in flight
    ack_dly = 100;
    base_addr = 32'h100;
    set_ch(0, 3'd1, 4'd1, 2'b00, '0);
    step();
    step();
    check("mid_req_before", bif.bus_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_req", bif.bus_req, 0);
    check("mid_busy", ch_busy, 0);
    check("mid_done", ch_done, 0);
    check("mid_value", ch_value, 0);
    check("mid_ptr", ch_ptr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    step();
    check("post_busy", ch_busy, 0);
    check("post_req", bif.bus_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
